// File: rtl/dram_arbiter_pkg.sv
// Shared encodings for the DataRAM arbiter: FSM states and requester identifiers.
package dram_arbiter_pkg;
   typedef enum logic {ST_RR = 1'b0, ST_LOCK = 1'b1} state_t;
   typedef enum logic {PORT_CPU = 1'b0, PORT_DBG = 1'b1} port_t;
endpackage

// File: rtl/dram_arbiter_rr_arb2.sv
// Two-requester round-robin pick: on a tie the port that was not granted last wins.
// Purely combinational, zero latency; the losing requester simply sees no grant.
module rr_arb2
   import dram_arbiter_pkg::*;
(
   input  logic [1:0] i_req,   // bit 0 = CPU, bit 1 = DBG
   input  logic       i_last,
   output logic [1:0] o_gnt
);
   always_comb begin
      o_gnt = i_req;
      if (&i_req) begin
         o_gnt = (i_last == PORT_DBG) ? 2'b01 : 2'b10;
      end
   end
endmodule

// File: rtl/dram_arbiter.sv
// Shares one async-read DataRAM between the CPU MEM stage and a debug/loader port.
// Access completes in the grant cycle, read data returns registered one cycle later; the CPU stalls when not granted.
module dram_arbiter
   import dram_arbiter_pkg::*;
#(
   parameter int AW       = 6,
   parameter int LOCK_MAX = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [31:0]   cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [31:0]   dbg_wdata,
   input  logic          dbg_lock,
   output logic          dbg_gnt,
   output logic [AW-1:0] ram_a,
   output logic [31:0]   ram_d,
   output logic          ram_we,
   input  logic [31:0]   ram_spo,
   output logic [31:0]   cpu_rdata,
   output logic [31:0]   dbg_rdata,
   output logic          cpu_rvalid,
   output logic          dbg_rvalid
);
   localparam int CW = $clog2(LOCK_MAX + 1);

   state_t        r_state;
   port_t         r_last;
   logic [CW-1:0] r_lock_cnt;
   logic [31:0]   r_cpu_rdata;
   logic [31:0]   r_dbg_rdata;
   logic          r_cpu_rvalid;
   logic          r_dbg_rvalid;

   logic [1:0]    w_rr_gnt;
   logic          w_lock_full;
   logic          w_lock_hold;
   logic          w_cpu_gnt;
   logic          w_dbg_gnt;

   rr_arb2 u_rr_arb2 (
      .i_req  ({dbg_req, cpu_req}),
      .i_last (r_last),
      .o_gnt  (w_rr_gnt)
   );

   // A full lock counter yields to a waiting CPU, bounding its wait to LOCK_MAX cycles.
   assign w_lock_full = (r_lock_cnt == CW'(LOCK_MAX));
   assign w_lock_hold = dbg_req & dbg_lock & ~(w_lock_full & cpu_req);

   always_comb begin
      w_cpu_gnt = 1'b0;
      w_dbg_gnt = 1'b0;
      if (!reset) begin
         if (r_state == ST_RR) begin
            w_cpu_gnt = w_rr_gnt[0];
            w_dbg_gnt = w_rr_gnt[1];
         end else if (w_lock_hold) begin
            w_dbg_gnt = 1'b1;
         end else begin
            w_cpu_gnt = cpu_req;
            w_dbg_gnt = dbg_req & ~cpu_req;
         end
      end
   end

   assign cpu_gnt   = w_cpu_gnt;
   assign dbg_gnt   = w_dbg_gnt;
   assign cpu_stall = cpu_req & ~w_cpu_gnt;

   assign ram_we = (w_cpu_gnt & cpu_we) | (w_dbg_gnt & dbg_we);
   assign ram_a  = w_cpu_gnt ? cpu_addr  : (w_dbg_gnt ? dbg_addr  : '0);
   assign ram_d  = w_cpu_gnt ? cpu_wdata : (w_dbg_gnt ? dbg_wdata : '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_RR;
         r_last       <= PORT_DBG;
         r_lock_cnt   <= '0;
         r_cpu_rdata  <= '0;
         r_dbg_rdata  <= '0;
         r_cpu_rvalid <= 1'b0;
         r_dbg_rvalid <= 1'b0;
      end else begin
         if (w_cpu_gnt) begin
            r_last <= PORT_CPU;
         end else if (w_dbg_gnt) begin
            r_last <= PORT_DBG;
         end

         if (r_state == ST_RR) begin
            if (w_dbg_gnt && dbg_lock) begin
               r_state    <= ST_LOCK;
               r_lock_cnt <= CW'(1);
            end
         end else if (w_lock_hold) begin
            if (!w_lock_full) begin
               r_lock_cnt <= r_lock_cnt + CW'(1);
            end
         end else begin
            r_state    <= ST_RR;
            r_lock_cnt <= '0;
         end

         r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
         r_dbg_rvalid <= w_dbg_gnt & ~dbg_we;
         if (w_cpu_gnt && !cpu_we) begin
            r_cpu_rdata <= ram_spo;
         end
         if (w_dbg_gnt && !dbg_we) begin
            r_dbg_rdata <= ram_spo;
         end
      end
   end

   assign cpu_rdata  = r_cpu_rdata;
   assign dbg_rdata  = r_dbg_rdata;
   assign cpu_rvalid = r_cpu_rvalid;
   assign dbg_rvalid = r_dbg_rvalid;
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus random traffic against a behavioural arbiter model.
module tb_dram_arbiter;
   localparam int AW       = 6;
   localparam int LOCK_MAX = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [31:0]   cpu_wdata = '0;
   logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
   logic [AW-1:0] dbg_addr = '0;
   logic [31:0]   dbg_wdata = '0;
   logic          cpu_gnt, cpu_stall, dbg_gnt, ram_we, cpu_rvalid, dbg_rvalid;
   logic [AW-1:0] ram_a;
   logic [31:0]   ram_d, ram_spo, cpu_rdata, dbg_rdata;

   logic [31:0]   ram [2**AW] = '{default: '0};

   dram_arbiter #(.AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
      .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_spo(ram_spo),
      .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata), .cpu_rvalid(cpu_rvalid), .dbg_rvalid(dbg_rvalid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (ram_we) ram[ram_a] <= ram_d;
   assign ram_spo = ram[ram_a];

   // Reference model: locked flag, who was served last, dbg grants in the current burst.
   bit            m_lock, m_last_dbg;
   int            m_cnt;
   bit            e_cg, e_dg, e_we, e_crv, e_drv;
   logic [AW-1:0] e_a;
   logic [31:0]   e_d, e_crd, e_drd, p_crd, p_drd;
   int            n_checks = 0, n_err = 0;

   function automatic void model_reset();
      m_lock = 0; m_last_dbg = 1; m_cnt = 0;
      e_crv = 0; e_drv = 0; e_crd = '0; e_drd = '0;
   endfunction

   function automatic void model_eval();
      e_cg = 0; e_dg = 0;
      if (!reset) begin
         if (!m_lock) begin
            if (cpu_req && dbg_req) begin
               e_cg = m_last_dbg; e_dg = !m_last_dbg;
            end else begin
               e_cg = cpu_req; e_dg = dbg_req;
            end
         end else if (dbg_req && dbg_lock && !(m_cnt >= LOCK_MAX && cpu_req)) begin
            e_dg = 1;
         end else begin
            e_cg = cpu_req; e_dg = dbg_req && !cpu_req;
         end
      end
      e_we  = (e_cg && cpu_we) || (e_dg && dbg_we);
      e_a   = e_cg ? cpu_addr : (e_dg ? dbg_addr : '0);
      e_d   = e_cg ? cpu_wdata : (e_dg ? dbg_wdata : '0);
      p_crd = ram[cpu_addr];
      p_drd = ram[dbg_addr];
   endfunction

   function automatic void model_commit();
      if (e_cg || e_dg) m_last_dbg = e_dg;
      if (e_dg && dbg_lock) begin
         m_cnt  = m_lock ? m_cnt + 1 : 1;
         m_lock = 1;
      end else if (m_lock) begin
         m_lock = 0; m_cnt = 0;
      end
      e_crv = e_cg && !cpu_we;
      e_drv = e_dg && !dbg_we;
      if (e_crv) e_crd = p_crd;
      if (e_drv) e_drd = p_drd;
   endfunction

   task automatic sample();
      @(negedge clk);
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk);
      if (reset) model_reset(); else model_commit();
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; dbg_req = 0; dbg_we = 0; dbg_lock = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 0;
   endtask

   task automatic test_reset();
      cpu_req = 1; cpu_we = 1; dbg_req = 1; dbg_we = 1;
      sample();
      n_checks++; if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL reset_cpu_gnt: got %b want 0", cpu_gnt); end
      n_checks++; if (dbg_gnt !== 1'b0) begin n_err++; $display("FAIL reset_dbg_gnt: got %b want 0", dbg_gnt); end
      n_checks++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
      n_checks++; if (cpu_stall !== 1'b1) begin n_err++; $display("FAIL reset_cpu_stall: got %b want 1", cpu_stall); end
      n_checks++; if ({cpu_rvalid, dbg_rvalid} !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b want 00", {cpu_rvalid, dbg_rvalid}); end
      n_checks++; if ({cpu_rdata, dbg_rdata} !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", {cpu_rdata, dbg_rdata}); end
      advance();
      idle_inputs();
      reset = 0;
   endtask

   task automatic test_cpu_write();
      cpu_req = 1; cpu_we = 1; cpu_addr = 6'h05; cpu_wdata = 32'hDEADBEEF;
      sample();
      n_checks++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL wr_cpu_gnt: got %b want 1", cpu_gnt); end
      n_checks++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL wr_ram_we: got %b want 1", ram_we); end
      n_checks++; if (ram_a !== 6'h05) begin n_err++; $display("FAIL wr_ram_a: got %h want 05", ram_a); end
      n_checks++; if (ram_d !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_ram_d: got %h want deadbeef", ram_d); end
      n_checks++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL wr_cpu_stall: got %b want 0", cpu_stall); end
      advance();
      idle_inputs();
      sample();
      n_checks++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid: got %b want 0", cpu_rvalid); end
      n_checks++; if (cpu_rdata !== 32'h0) begin n_err++; $display("FAIL wr_rdata_hold: got %h want 0", cpu_rdata); end
      n_checks++; if (ram[5] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_ram_content: got %h want deadbeef", ram[5]); end
      advance();
   endtask

   task automatic test_dbg_read();
      dbg_req = 1; dbg_we = 1; dbg_addr = 6'h09; dbg_wdata = 32'h12345678;
      sample();
      advance();
      dbg_we = 0;
      sample();
      n_checks++; if (dbg_gnt !== 1'b1 || ram_we !== 1'b0) begin n_err++; $display("FAIL rd_dbg_gnt: got gnt=%b we=%b want gnt=1 we=0", dbg_gnt, ram_we); end
      advance();
      idle_inputs();
      sample();
      n_checks++; if (dbg_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_dbg_rvalid: got %b want 1", dbg_rvalid); end
      n_checks++; if (dbg_rdata !== 32'h12345678) begin n_err++; $display("FAIL rd_dbg_rdata: got %h want 12345678", dbg_rdata); end
      n_checks++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_cpu_rvalid: got %b want 0", cpu_rvalid); end
      advance();
      sample();
      n_checks++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_pulse_width: got %b want 0", dbg_rvalid); end
      n_checks++; if (dbg_rdata !== 32'h12345678) begin n_err++; $display("FAIL rd_rdata_hold: got %h want 12345678", dbg_rdata); end
      advance();
   endtask

   task automatic test_alternate();
      do_reset();
      cpu_req = 1; dbg_req = 1; cpu_addr = 6'h05; dbg_addr = 6'h09;
      for (int i = 0; i < 8; i++) begin
         sample();
         n_checks++;
         if (cpu_gnt !== (i % 2 == 0) || dbg_gnt !== (i % 2 == 1)) begin
            n_err++; $display("FAIL alt_grant[%0d]: got cpu=%b dbg=%b want cpu=%b", i, cpu_gnt, dbg_gnt, (i % 2 == 0));
         end
         if (i > 0) begin
            n_checks++;
            if (cpu_rvalid !== (i % 2 == 1) || dbg_rvalid !== (i % 2 == 0)) begin
               n_err++; $display("FAIL alt_rvalid[%0d]: got cpu=%b dbg=%b want cpu=%b", i, cpu_rvalid, dbg_rvalid, (i % 2 == 1));
            end
         end
         advance();
      end
      idle_inputs();
   endtask

   task automatic test_lock_burst();
      int n_dbg = 0;
      do_reset();
      cpu_req = 1; dbg_req = 1; dbg_lock = 1;
      for (int i = 0; i < LOCK_MAX + 2; i++) begin
         sample();
         if (dbg_gnt) n_dbg++;
         n_checks++;
         if (cpu_gnt !== (i == 0 || i == LOCK_MAX + 1) || cpu_stall !== !(i == 0 || i == LOCK_MAX + 1)) begin
            n_err++; $display("FAIL lock_burst[%0d]: got cpu_gnt=%b stall=%b dbg_gnt=%b", i, cpu_gnt, cpu_stall, dbg_gnt);
         end
         advance();
      end
      n_checks++; if (n_dbg != LOCK_MAX) begin n_err++; $display("FAIL lock_burst_len: got %0d want %0d", n_dbg, LOCK_MAX); end
      idle_inputs();
   endtask

   task automatic test_reset_mid_lock();
      do_reset();
      dbg_req = 1; dbg_lock = 1;
      sample(); advance();
      cpu_req = 1;
      for (int i = 0; i < 3; i++) begin
         sample();
         n_checks++; if (dbg_gnt !== 1'b1) begin n_err++; $display("FAIL mid_lock_dbg[%0d]: got %b want 1", i, dbg_gnt); end
         advance();
      end
      reset = 1;
      model_reset();
      #1;
      n_checks++; if ({cpu_gnt, dbg_gnt, ram_we} !== 3'b000) begin n_err++; $display("FAIL mid_lock_rst_gnt: got %b want 000", {cpu_gnt, dbg_gnt, ram_we}); end
      n_checks++; if (dbg_rvalid !== 1'b0 || cpu_stall !== 1'b1) begin n_err++; $display("FAIL mid_lock_rst_state: got rvalid=%b stall=%b", dbg_rvalid, cpu_stall); end
      @(posedge clk);
      #1;
      reset = 0;
      sample();
      n_checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin n_err++; $display("FAIL mid_lock_cpu_first: got cpu=%b dbg=%b want 1 0", cpu_gnt, dbg_gnt); end
      advance();
      idle_inputs();
   endtask

   task automatic test_lock_drop();
      do_reset();
      dbg_req = 1; dbg_lock = 1;
      sample(); advance();
      cpu_req = 1;
      for (int i = 0; i < 2; i++) begin
         sample();
         n_checks++; if (dbg_gnt !== 1'b1) begin n_err++; $display("FAIL drop_dbg[%0d]: got %b want 1", i, dbg_gnt); end
         advance();
      end
      dbg_lock = 0;
      sample();
      n_checks++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin n_err++; $display("FAIL drop_cpu_gnt: got cpu=%b dbg=%b want 1 0", cpu_gnt, dbg_gnt); end
      advance();
      sample();
      n_checks++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin n_err++; $display("FAIL drop_rr_resume: got cpu=%b dbg=%b want 0 1", cpu_gnt, dbg_gnt); end
      advance();
      idle_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         reset     = ($urandom_range(0, 79) == 0);
         if (reset) model_reset();
         cpu_req   = ($urandom_range(0, 3) != 0);
         cpu_we    = $urandom_range(0, 1);
         cpu_addr  = AW'($urandom_range(0, 7));
         cpu_wdata = $urandom;
         dbg_req   = ($urandom_range(0, 3) != 0);
         dbg_we    = $urandom_range(0, 1);
         dbg_addr  = AW'($urandom_range(0, 7));
         dbg_wdata = $urandom;
         dbg_lock  = ($urandom_range(0, 7) != 0);
         sample();
         n_checks++; if (cpu_gnt !== e_cg || dbg_gnt !== e_dg) begin n_err++; $display("FAIL rnd_gnt[%0d]: got cpu=%b dbg=%b want cpu=%b dbg=%b", i, cpu_gnt, dbg_gnt, e_cg, e_dg); end
         n_checks++; if (cpu_gnt && dbg_gnt) begin n_err++; $display("FAIL rnd_exclusive[%0d]: got both grants want at most one", i); end
         n_checks++; if (cpu_stall !== (cpu_req && !e_cg)) begin n_err++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, cpu_stall, cpu_req && !e_cg); end
         n_checks++; if (ram_we !== e_we || ram_a !== e_a || ram_d !== e_d) begin n_err++; $display("FAIL rnd_ram[%0d]: got we=%b a=%h d=%h want we=%b a=%h d=%h", i, ram_we, ram_a, ram_d, e_we, e_a, e_d); end
         n_checks++; if (cpu_rvalid !== e_crv || cpu_rdata !== e_crd) begin n_err++; $display("FAIL rnd_cpu_ret[%0d]: got v=%b d=%h want v=%b d=%h", i, cpu_rvalid, cpu_rdata, e_crv, e_crd); end
         n_checks++; if (dbg_rvalid !== e_drv || dbg_rdata !== e_drd) begin n_err++; $display("FAIL rnd_dbg_ret[%0d]: got v=%b d=%h want v=%b d=%h", i, dbg_rvalid, dbg_rdata, e_drv, e_drd); end
         advance();
      end
      reset = 0;
      idle_inputs();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_cpu_write();
      test_dbg_read();
      test_alternate();
      test_lock_burst();
      test_reset_mid_lock();
      test_lock_drop();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter AW, default 6, word-address width of the shared DataRAM.
REQ-002 Parameter LOCK_MAX, default 16, maximum consecutive debug-port grants under lock.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_req  input  1  pipeline MEM-stage access request; cpu_we  input  1  write enable.
REQ-006 cpu_addr  input  AW  word address; cpu_wdata  input  32  store data.
REQ-007 cpu_gnt  output  1  CPU access performed this cycle; cpu_stall  output  1  = cpu_req & ~cpu_gnt, drives the pipeline Stall.
REQ-008 dbg_req, dbg_we, dbg_addr[AW], dbg_wdata[32]  inputs  debug/loader port, same meaning as the CPU port.
REQ-009 dbg_lock  input  1  debug burst lock request; dbg_gnt  output  1  debug access performed this cycle.
REQ-010 ram_a  output  AW, ram_d  output  32, ram_we  output  1, ram_spo  input  32  shared DataRAM with asynchronous read.
REQ-011 cpu_rdata, dbg_rdata  output  32 each; cpu_rvalid, dbg_rvalid  output  1 each  registered read return.

Function
REQ-012 At most one of cpu_gnt and dbg_gnt SHALL be high in any cycle.
REQ-013 Grant SHALL be combinational from requests, FSM state and the last-grant register; the access completes in the grant cycle.
REQ-014 The RAM port SHALL be driven from the granted requester; with no grant, ram_we = 0 and ram_a/ram_d = 0.
REQ-015 ram_we SHALL equal the granted requester's we; a write with no grant SHALL never reach the RAM.
REQ-016 A read grant SHALL capture ram_spo into that port's rdata and pulse its rvalid for exactly one cycle on the following cycle.
REQ-017 After a write grant, rvalid SHALL stay 0 and rdata SHALL hold its previous value.
REQ-018 FSM states: RR (round-robin) and LOCK.
REQ-019 In RR: single request wins; on simultaneous requests the port not granted last wins; last SHALL update on every grant.
REQ-020 RR -> LOCK when dbg is granted with dbg_lock = 1; lock_cnt SHALL load 1.
REQ-021 In LOCK: dbg SHALL be granted whenever dbg_req = 1, regardless of cpu_req; lock_cnt SHALL increment per dbg grant.
REQ-022 LOCK -> RR when dbg_lock = 0, or when dbg_req = 0 (the CPU is then granted in that cycle if it requests).
REQ-023 LOCK -> RR when lock_cnt = LOCK_MAX and cpu_req = 1; that cycle the CPU SHALL be granted and last = CPU, bounding CPU wait to LOCK_MAX cycles.
REQ-024 Addresses SHALL pass unmodified; no wrap or range check is performed.

Reset
REQ-025 While reset is high, cpu_gnt, dbg_gnt, ram_we SHALL be 0, and cpu_stall SHALL equal cpu_req.
REQ-026 Reset SHALL set state = RR, last = DBG (CPU wins the first tie), lock_cnt = 0, rdata = 0, rvalid = 0.
REQ-027 Reset asserted mid-lock SHALL abort the burst; no partial state survives.

Structure
REQ-028 State encodings and the CPU/DBG port identifiers SHALL live in a shared package; AW and LOCK_MAX remain module parameters.
REQ-029 The round-robin grant decision SHALL be one sub-module, rr_arb2: two requests, last pointer in, one-hot grant out.

Verification
REQ-030 Only cpu_req with we = 1, addr 0x05, wdata 0xDEADBEEF -> cpu_gnt = 1, ram_we = 1, ram_a = 0x05 that cycle, cpu_stall = 0.
REQ-031 Both ports request reads every cycle after reset -> grants alternate CPU, DBG, CPU, DBG; each rvalid pulses one cycle after its grant.
REQ-032 Debug read of a word holding 0x12345678 -> dbg_rvalid = 1 and dbg_rdata = 0x12345678 on the next cycle; cpu_rvalid stays 0.
REQ-033 dbg_lock = 1, dbg_req held, cpu_req held, LOCK_MAX = 16 -> 16 consecutive dbg grants, then 1 CPU grant; cpu_stall = 1 during the 16 cycles.
REQ-034 Reset pulsed during a lock burst -> grants 0 immediately; after release with both requests, the CPU is granted first.
REQ-035 dbg_lock dropped mid-burst with both requests -> return to RR; the CPU is granted in that cycle.
